seg7_scan4: RTL and testbench
=============================

Name: seg7_scan4

Overview:
Downstream display stage for the BCD up-counters. It takes four BCD digits (ones/tens from one counter pair, plus two more) and time-multiplexes them onto a 4-digit common-anode 7-segment display. It drives active-low digit enables and active-low segments. Inputs are snapshotted once per frame so the display never tears. Optional leading-zero blanking and per-digit decimal points are supported.

Parameters:
SCAN_DIV, 100000, clk cycles each digit is held active (legal range 2..2^20); frame length = 4*SCAN_DIV cycles
CNT_W, 20, width of the internal scan counter; must satisfy 2^CNT_W >= SCAN_DIV

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
dig0  input  4  BCD ones digit (rightmost)
dig1  input  4  BCD tens digit
dig2  input  4  BCD hundreds digit
dig3  input  4  BCD thousands digit (leftmost)
dp_en  input  4  decimal point request per digit; bit i = digit i
lzb_en  input  1  1 = blank leading zeros
ssd_ctl  output  4  digit enables, active-low one-hot; bit i = digit i
ssd_out  output  8  segments {a,b,c,d,e,f,g,dp}, active-low
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. No asynchronous logic.
- Reset (rst=1 at an edge): scan_cnt=0, idx=0, snapshot (4 digits, dp_en, lzb_en)=all 0, ssd_ctl=4'hF, ssd_out=8'hFF, frame_done=0.
- Reset mid-frame behaves identically. Outputs go dark on the next edge, and the scan restarts from digit 0 with a zero snapshot.
- Scan counter: scan_cnt counts 0..SCAN_DIV-1 and wraps. tick = (scan_cnt==SCAN_DIV-1).
- Digit index: on tick, idx advances 0->1->2->3->0. Otherwise it holds.
- Snapshot: loaded from dig0..3, dp_en and lzb_en only in the cycle where tick && idx==3. The loaded value is used for the whole next frame.
- First frame after reset displays the zero snapshot. Input changes at any other time have no visible effect until the next frame.
- Output latency: ssd_ctl, ssd_out and frame_done are registered. In cycle c they reflect idx and snapshot from cycle c-1.
- Digit enable: ssd_ctl = ~(4'b0001 << idx), unless digit idx is blanked, in which case ssd_ctl = 4'hF.
- Blanking applies only when the snapshot lzb=1:
  - digit3 blanked if s3==0
  - digit2 blanked if s3==0 && s2==0
  - digit1 blanked if s3==s2==s1==0
  - digit0 is never blanked
- Segment decode of snapshot digit s[idx] ({a..g,dp=1}):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99
  - 5=49, 6=41, 7=1F, 8=01, 9=09
  - any value 10..15 = 61 ("E")
- Decimal point: if the snapshot dp[idx]=1, bit0 (dp) is cleared.
- Blanked digit: ssd_out=8'hFF, and the dp is suppressed as well.
- frame_done: high for exactly one cycle, the cycle after the snapshot load (the tick && idx==3 cycle). It is never high during reset or in the first frame's start.
- No two enables are ever low simultaneously; exactly one or zero bits of ssd_ctl are 0 in every cycle.

Test Plan:
- Reset/first frame (SCAN_DIV=4): release rst at cycle 0 -> cycle 0: ctl=F, out=FF. Cycles 1-4: ctl=E, out=03. Cycles 5-8: ctl=D, out=03. Continues through digit3 with all digits showing "0" (lzb snapshot=0).
- Snapshot timing: drive dig3..0=1,2,3,4 from cycle 2 -> frame 0 still shows 0s. Load occurs at cycle 15; frame_done=1 in cycle 16 only. Cycles 17-20: ctl=E, out=99 ("4"); then D/0D, B/25, 7/9F.
- Leading-zero blanking: digits 0,0,5,0 (dig3..0), lzb_en=1 -> digit3 and digit2 slots show ctl=F, out=FF. Digit1 shows ctl=D, out=49; digit0 shows ctl=E, out=03. All zeros -> only digit0 lit with 03.
- DP and invalid BCD: dig0=4'hC, dp_en=4'b0001 -> digit0 out=60. dp_en=4'b1000 with digit3 blanked -> digit3 out=FF.
- Mid-frame reset: assert rst for 1 cycle during idx=2 -> next cycle ctl=F, out=FF. Scan restarts at digit 0 with zeros, and no frame_done pulse until 4*SCAN_DIV cycles later.
- Tear-free: toggle dig1 every cycle -> the displayed digit1 value is constant within every frame and equals the dig1 value at the load cycle.

Source files
------------

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed driver for a common-anode 7-segment display.
// Inputs are captured once per frame so that a frame never mixes old and new digits.
module seg7_scan4 #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dp_en,
    input  logic       lzb_en,
    output logic [3:0] ssd_ctl,
    output logic [7:0] ssd_out,
    output logic       frame_done
);

    logic [CNT_W-1:0]     scan_cnt_r;
    logic [1:0]           idx_r;
    logic [3:0][3:0]      snap_dig_r;
    logic [3:0]           snap_dp_r;
    logic                 snap_lzb_r;

    logic                 tick_s;
    logic                 load_s;
    logic [3:0]           cur_dig_s;
    logic                 blank_s;
    logic [3:0]           ctl_nxt_s;
    logic [7:0]           out_nxt_s;

    // Segment pattern {a..g,dp} with dp off; non-BCD values show "E".
    function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
        logic [7:0] seg;
        case (bcd)
            4'd0:    seg = 8'h03;
            4'd1:    seg = 8'h9F;
            4'd2:    seg = 8'h25;
            4'd3:    seg = 8'h0D;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h49;
            4'd6:    seg = 8'h41;
            4'd7:    seg = 8'h1F;
            4'd8:    seg = 8'h01;
            4'd9:    seg = 8'h09;
            default: seg = 8'h61;
        endcase
        return seg;
    endfunction

    // Next-cycle digit enable and segment values from the current scan slot.
    always_comb begin
        tick_s    = (scan_cnt_r == CNT_W'(SCAN_DIV - 1));
        load_s    = tick_s && (idx_r == 2'd3);
        cur_dig_s = snap_dig_r[idx_r];
        blank_s   = 1'b0;
        if (snap_lzb_r) begin
            case (idx_r)
                2'd3:    blank_s = (snap_dig_r[3] == 4'd0);
                2'd2:    blank_s = (snap_dig_r[3] == 4'd0) && (snap_dig_r[2] == 4'd0);
                2'd1:    blank_s = (snap_dig_r[3] == 4'd0) && (snap_dig_r[2] == 4'd0)
                                   && (snap_dig_r[1] == 4'd0);
                default: blank_s = 1'b0;
            endcase
        end else begin
            blank_s = 1'b0;
        end
        if (blank_s) begin
            ctl_nxt_s = 4'hF;
            out_nxt_s = 8'hFF;
        end else begin
            ctl_nxt_s = ~(4'b0001 << idx_r);
            out_nxt_s = seg_decode(cur_dig_s) & {7'h7F, ~snap_dp_r[idx_r]};
        end
    end

    // Scan counter, digit index, frame snapshot and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r <= '0;
            idx_r      <= 2'd0;
            snap_dig_r <= '0;
            snap_dp_r  <= 4'h0;
            snap_lzb_r <= 1'b0;
            ssd_ctl    <= 4'hF;
            ssd_out    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            if (tick_s) begin
                scan_cnt_r <= '0;
                idx_r      <= idx_r + 2'd1;
            end else begin
                scan_cnt_r <= scan_cnt_r + CNT_W'(1);
                idx_r      <= idx_r;
            end
            if (load_s) begin
                snap_dig_r <= {dig3, dig2, dig1, dig0};
                snap_dp_r  <= dp_en;
                snap_lzb_r <= lzb_en;
            end else begin
                snap_dig_r <= snap_dig_r;
                snap_dp_r  <= snap_dp_r;
                snap_lzb_r <= snap_lzb_r;
            end
            ssd_ctl    <= ctl_nxt_s;
            ssd_out    <= out_nxt_s;
            frame_done <= load_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan4.sv
// Directed bench for seg7_scan4 with a cycle-stamped expectation queue
// drained by an independent monitor on the falling edge.
module tb_seg7_scan4;

    localparam int R = 2;   // posedge count at which display cycle 0 begins

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dig0 = 4'd0, dig1 = 4'd0, dig2 = 4'd0, dig3 = 4'd0;
    logic [3:0] dp_en = 4'h0;
    logic       lzb_en = 1'b0;
    logic [3:0] ssd_ctl;
    logic [7:0] ssd_out;
    logic       frame_done;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         c;
        logic [3:0] ctl;
        logic [7:0] out;
        logic       fd;
    } exp_t;

    exp_t q[$];
    exp_t e;

    seg7_scan4 #(.SCAN_DIV(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .dp_en(dp_en), .lzb_en(lzb_en),
        .ssd_ctl(ssd_ctl), .ssd_out(ssd_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due this cycle and compare.
    always @(negedge clk) begin
        if (cyc >= R) begin
            n_cmp++;
            if ($countones(~ssd_ctl) > 1) begin
                n_bad++;
                $display("FAIL onehot cyc=%0d ctl=%h has more than one enable low", cyc - R, ssd_ctl);
            end
        end
        while (q.size() > 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.c != cyc) begin
                n_bad++;
                $display("FAIL sched expectation for cyc=%0d seen at cyc=%0d", e.c - R, cyc - R);
            end else if (ssd_ctl !== e.ctl || ssd_out !== e.out || frame_done !== e.fd) begin
                n_bad++;
                $display("FAIL disp cyc=%0d got ctl=%h out=%h fd=%b expected ctl=%h out=%h fd=%b",
                         cyc - R, ssd_ctl, ssd_out, frame_done, e.ctl, e.out, e.fd);
            end
        end
    end

    task automatic push(input int c, input logic [3:0] ctl, input logic [7:0] out, input logic fd);
        exp_t x;
        x.c = R + c; x.ctl = ctl; x.out = out; x.fd = fd;
        q.push_back(x);
    endtask

    // A full frame starting at display cycle f; frame_done falls on its last cycle.
    task automatic push_frame(input int f, input logic [3:0][3:0] ctls, input logic [3:0][7:0] outs);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                push(f + 4*i + k, ctls[i], outs[i], (i == 3) && (k == 3));
    endtask

    task automatic goto(input int c);
        while (cyc < R + c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push(0, 4'hF, 8'hFF, 1'b0);
        push_frame(1, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h03, 8'h03, 8'h03, 8'h03});

        // Inputs change inside frame 0 and appear only from frame 1.
        goto(2);
        dig3 = 4'd1; dig2 = 4'd2; dig1 = 4'd3; dig0 = 4'd4;
        push_frame(17, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h9F, 8'h25, 8'h0D, 8'h99});

        // Leading-zero blanking, dp request on a blanked digit.
        goto(20);
        dig3 = 4'd0; dig2 = 4'd0; dig1 = 4'd5; dig0 = 4'd0; lzb_en = 1'b1; dp_en = 4'b1000;
        push_frame(33, {4'hF, 4'hF, 4'hD, 4'hE}, {8'hFF, 8'hFF, 8'h49, 8'h03});

        goto(36);
        dig1 = 4'd0; dp_en = 4'b0000;
        push_frame(49, {4'hF, 4'hF, 4'hF, 4'hE}, {8'hFF, 8'hFF, 8'hFF, 8'h03});

        // Invalid BCD with decimal point, plus 6/7/8.
        goto(52);
        dig3 = 4'd8; dig2 = 4'd7; dig1 = 4'd6; dig0 = 4'hC; lzb_en = 1'b0; dp_en = 4'b0001;
        push_frame(65, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h01, 8'h1F, 8'h41, 8'h60});

        // dig1 toggles 2/9 every cycle; loads at cycles 79 and 95 (odd) capture 9.
        goto(66);
        dig3 = 4'd3; dig2 = 4'd0; dig0 = 4'd9; dp_en = 4'b0000;
        push_frame(81, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h0D, 8'h03, 8'h09, 8'h09});
        for (int c = 97; c <= 100; c++) push(c, 4'hE, 8'h09, 1'b0);
        for (int c = 101; c <= 104; c++) push(c, 4'hD, 8'h09, 1'b0);
        push(105, 4'hB, 8'h03, 1'b0);
        push(106, 4'hF, 8'hFF, 1'b0);
        push_frame(107, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h03, 8'h03, 8'h03, 8'h03});
        for (int c = 66; c <= 104; c++) begin
            goto(c);
            dig1 = (c % 2 == 1) ? 4'd9 : 4'd2;
        end

        // One-cycle reset while digit 2 is on.
        goto(105);
        rst = 1'b1;
        goto(106);
        rst = 1'b0;

        goto(107);
        dig3 = 4'd9; dig2 = 4'd9; dig1 = 4'd9; dig0 = 4'd9;
        push_frame(123, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h09, 8'h09, 8'h09, 8'h09});

        goto(140);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
